regfile_writeback: RTL and testbench

Write-back queue that drives the general-purpose register file write port (data, index, enable). Results from the ALU and the load unit are accepted over valid/ready handshakes, buffered in an in-order FIFO, and retired one per cycle as registered write commands. A pending-write bitmask lets the issue stage stall on registers with writes still in flight. Writes to x0 are accepted and discarded.

---
 rtl/regfile_writeback.sv | 142 ++++++++++++++
 tb/tb_regfile_writeback.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue in front of the register file write port.
//
// Load and ALU results arrive over valid/ready handshakes. Results aimed at x0 are
// accepted and dropped. All other results are buffered in a DEPTH-entry FIFO. The
// head of the FIFO is retired one per cycle as a registered write command.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ld_valid/ready/idx/data       load unit result handshake
//   alu_valid/ready/idx/data      ALU result handshake
//   wr_en/wr_idx/wr_data          registered register-file write command
//   pend                          per-register "write still in flight" mask (bit 0 always 0)
//   count/full/empty              FIFO occupancy
module regfile_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [4:0]             ld_idx,
    input  logic [XLEN-1:0]        ld_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [4:0]             alu_idx,
    input  logic [XLEN-1:0]        alu_data,
    output logic                   wr_en,
    output logic [4:0]             wr_idx,
    output logic [XLEN-1:0]        wr_data,
    output logic [31:0]            pend,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

    logic [4:0]      idx_q  [DEPTH];
    logic [4:0]      idx_d  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] alu_slot;
    logic [PtrW-1:0] offset;
    logic [CntW-1:0] count_q, count_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_idx_q, wr_idx_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            ld_nz, alu_nz;
    logic            ld_push, alu_push, pop;
    logic [31:0]     pend_c;

    // Readiness is based on the occupancy at the start of the cycle only; a
    // same-cycle retire never makes room for a push.
    always_comb begin
        ld_nz     = (ld_idx != 5'd0);
        alu_nz    = (alu_idx != 5'd0);
        ld_ready  = (count_q != CntFull);
        // The ALU may take the last free slot only if the load is not claiming it.
        alu_ready = (count_q < CntLast) || ((count_q == CntLast) && !(ld_valid && ld_nz));
        ld_push   = ld_valid && ld_ready && ld_nz;
        alu_push  = alu_valid && alu_ready && alu_nz;
        pop       = (count_q != '0);
    end

    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        // Load is the older instruction, so it takes the tail slot first.
        alu_slot = wptr_q + PtrW'(ld_push);
        if (ld_push) begin
            idx_d[wptr_q]  = ld_idx;
            data_d[wptr_q] = ld_data;
        end
        if (alu_push) begin
            idx_d[alu_slot]  = alu_idx;
            data_d[alu_slot] = alu_data;
        end
        wptr_d  = wptr_q + PtrW'(ld_push) + PtrW'(alu_push);
        rptr_d  = rptr_q + PtrW'(pop);
        count_d = count_q + CntW'(ld_push) + CntW'(alu_push) - CntW'(pop);

        // Write port holds its last index/data when nothing retires.
        wr_en_d   = pop;
        wr_idx_d  = pop ? idx_q[rptr_q] : wr_idx_q;
        wr_data_d = pop ? data_q[rptr_q] : wr_data_q;
    end

    // Entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        pend_c = '0;
        offset = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset = PtrW'(i) - rptr_q;
            if (CntW'(offset) < count_q) begin
                pend_c[idx_q[i]] = 1'b1;
            end
        end
        if (wr_en_q) begin
            pend_c[wr_idx_q] = 1'b1;
        end
        pend_c[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            idx_q     <= idx_d;
            data_q    <= data_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;
    assign pend    = pend_c;
    assign count   = count_q;
    assign full    = (count_q == CntFull);
    assign empty   = (count_q == '0);

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random stress,
// all checked cycle by cycle against a queue-based reference model.
module tb_regfile_writeback;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, alu_valid;
    logic [4:0]  ld_idx, alu_idx;
    logic [31:0] ld_data, alu_data;

    logic        ld_ready, alu_ready, wr_en, full, empty;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data, pend;
    logic [2:0]  count;

    // Second instance with the minimum depth, where the queue can actually fill.
    logic        ld_ready2, alu_ready2, wr_en2, full2, empty2;
    logic [4:0]  wr_idx2;
    logic [31:0] wr_data2, pend2;
    logic [1:0]  count2;

    regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_idx(alu_idx), .alu_data(alu_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .pend(pend),
        .count(count), .full(full), .empty(empty)
    );

    regfile_writeback #(.DEPTH(2), .XLEN(XLEN)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_idx(ld_idx), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready2), .alu_idx(alu_idx), .alu_data(alu_data),
        .wr_en(wr_en2), .wr_idx(wr_idx2), .wr_data(wr_data2), .pend(pend2),
        .count(count2), .full(full2), .empty(empty2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_wr_en;
    logic [4:0]  m_wr_idx;
    logic [31:0] m_wr_data;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        foreach (mq[k]) p[mq[k].idx] = 1'b1;
        if (m_wr_en) p[m_wr_idx] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wr_en   = 1'b0;
        m_wr_idx  = '0;
        m_wr_data = '0;
    endtask

    task automatic set_in(input logic lv, input logic [4:0] li, input logic [31:0] ldd,
                          input logic av, input logic [4:0] ai, input logic [31:0] ad);
        ld_valid  = lv;
        ld_idx    = li;
        ld_data   = ldd;
        alu_valid = av;
        alu_idx   = ai;
        alu_data  = ad;
    endtask

    // Called just after a falling edge with inputs already driven: compare every
    // output against the model, then advance the model across the rising edge.
    task automatic cycle();
        int   s;
        logic m_ld_rdy, m_alu_rdy;
        ent_t e;
        #1;
        s         = mq.size();
        m_ld_rdy  = (s < int'(DEPTH));
        m_alu_rdy = (s <= int'(DEPTH) - 2) ||
                    ((s == int'(DEPTH) - 1) && !(ld_valid && ld_idx != 5'd0));
        check_eq("ld_ready", ld_ready, m_ld_rdy);
        check_eq("alu_ready", alu_ready, m_alu_rdy);
        check_eq("count", count, s);
        check_eq("count_bound", count <= DEPTH, 1);
        check_eq("full", full, s == int'(DEPTH));
        check_eq("empty", empty, s == 0);
        check_eq("wr_en", wr_en, m_wr_en);
        check_eq("wr_idx", wr_idx, m_wr_idx);
        check_eq("wr_data", wr_data, m_wr_data);
        check_eq("pend", pend, model_pend());
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (s > 0) begin
                e         = mq.pop_front();
                m_wr_en   = 1'b1;
                m_wr_idx  = e.idx;
                m_wr_data = e.data;
            end else begin
                m_wr_en = 1'b0;
            end
            if (ld_valid && m_ld_rdy && ld_idx != 5'd0)
                mq.push_back('{idx: ld_idx, data: ld_data});
            if (alu_valid && m_alu_rdy && alu_idx != 5'd0)
                mq.push_back('{idx: alu_idx, data: alu_data});
        end
        @(negedge clk);
    endtask

    initial begin
        logic       lv, av;
        logic [4:0] li, ai;

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        cycle();

        // Reset state
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_ld_ready", ld_ready, 1);
        check_eq("rst_alu_ready", alu_ready, 1);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_idx", wr_idx, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_pend", pend, 0);
        rst_n = 1'b1;
        cycle();
        cycle();

        // Single ALU write
        set_in(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        check_eq("sgl_pend5_queued", pend[5], 1);
        check_eq("sgl_wr_en_lat", wr_en, 0);
        cycle();
        check_eq("sgl_wr_en", wr_en, 1);
        check_eq("sgl_wr_idx", wr_idx, 5);
        check_eq("sgl_wr_data", wr_data, 32'hDEADBEEF);
        check_eq("sgl_pend5_wr", pend[5], 1);
        cycle();
        check_eq("sgl_wr_en_off", wr_en, 0);
        check_eq("sgl_pend_clr", pend, 0);

        // x0 discard
        set_in(1, 5'd0, 32'h1234, 0, 0, 0);
        #1;
        check_eq("x0_ld_ready", ld_ready, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        check_eq("x0_count", count, 0);
        cycle();
        check_eq("x0_wr_en", wr_en, 0);
        check_eq("x0_pend", pend, 0);

        // Simultaneous push to the same register
        set_in(1, 5'd3, 32'hA, 1, 5'd3, 32'hB);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        check_eq("sim_count", count, 2);
        check_eq("d2_full", full2, 1);
        check_eq("d2_count", count2, 2);
        check_eq("d2_ld_ready", ld_ready2, 0);
        check_eq("d2_alu_ready", alu_ready2, 0);
        cycle();
        check_eq("sim_wr0_idx", wr_idx, 3);
        check_eq("sim_wr0_data", wr_data, 32'hA);
        check_eq("sim_pend3_a", pend[3], 1);
        cycle();
        check_eq("sim_wr1_en", wr_en, 1);
        check_eq("sim_wr1_idx", wr_idx, 3);
        check_eq("sim_wr1_data", wr_data, 32'hB);
        check_eq("sim_pend3_b", pend[3], 1);
        cycle();
        check_eq("sim_pend_clr", pend, 0);

        // Fill / backpressure: both sources push every cycle
        for (int k = 0; k < 6; k++) begin
            set_in(1, 5'(k + 1), $urandom, 1, 5'(k + 9), $urandom);
            if (k >= 2) begin
                #1;
                check_eq("fill_alu_blocked", alu_ready, 0);
                check_eq("fill_ld_ready", ld_ready, 1);
            end
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0);
        repeat (5) cycle();

        // Reset mid-stream with three entries queued
        set_in(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        cycle();
        set_in(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        check_eq("mr_count", count, 3);
        check_eq("mr_wr_en_before", wr_en, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("mr_wr_en", wr_en, 0);
        check_eq("mr_count0", count, 0);
        check_eq("mr_pend", pend, 0);
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Random stress
        for (int c = 0; c < 10000; c++) begin
            lv = ($urandom_range(0, 99) < 60);
            av = ($urandom_range(0, 99) < 60);
            li = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ai = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            set_in(lv, li, $urandom, av, ai, $urandom);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0);
        repeat (6) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
